// File: rtl/decrypt_stream_ctrl.sv
// Byte-stream front end for the NewHope decrypter: loads input RAM, starts, reads message back, streams it out.
// Optional feature macro SK_RETAIN_EN: secret key loaded once and retained across ciphertext loads.
module decrypt_stream_ctrl #(
  parameter int CT_BYTES  = 1088,
  parameter int SK_BYTES  = 896,
  parameter int MSG_WORDS = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last,
  output logic        busy,
  output logic        dec_rst,
  output logic        dec_start,
  input  logic        dec_done,
  output logic [7:0]  dec_dia,
  output logic        dec_wea,
  output logic [10:0] dec_addra,
  output logic [2:0]  dec_out_addr,
  input  logic [31:0] dec_out_do
`ifdef SK_RETAIN_EN
  ,
  input  logic        key_load,
  output logic        key_valid
`endif
);

  localparam logic [2:0] S_LOAD  = 3'd0;
  localparam logic [2:0] S_FLUSH = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RD    = 3'd4;
  localparam logic [2:0] S_SEND  = 3'd5;

  localparam logic [10:0] LOAD_END = 11'(CT_BYTES + SK_BYTES);
  localparam logic [2:0]  LAST_W   = 3'(MSG_WORDS - 1);

  logic [2:0]  r_state;
  logic [10:0] r_cnt;
  logic [7:0]  r_dia;
  logic [10:0] r_addra;
  logic        r_wea;
  logic [2:0]  r_w;
  logic [1:0]  r_b;
  logic        r_first;
  logic [31:0] r_word;

  logic        w_accept;
  logic [10:0] w_base;
  logic [10:0] w_last;
  logic        w_load_done;
  logic [2:0]  w_after_load;
  logic [31:0] w_word;

  assign w_accept = in_valid && (r_state == S_LOAD);

`ifdef SK_RETAIN_EN
  logic r_key_mode;
  logic r_key_valid;
  logic w_key;

  // The load kind is decided by key_load on the first byte and then held for the whole load.
  assign w_key        = (r_cnt == 11'd0) ? key_load : r_key_mode;
  assign w_base       = w_key ? 11'(CT_BYTES) : 11'd0;
  assign w_last       = w_key ? 11'(SK_BYTES - 1) : 11'(CT_BYTES - 1);
  assign w_after_load = (w_key || !r_key_valid) ? S_LOAD : S_FLUSH;
  assign key_valid    = r_key_valid;
`else
  assign w_base       = 11'd0;
  assign w_last       = LOAD_END - 11'd1;
  assign w_after_load = S_FLUSH;
`endif

  assign w_load_done = w_accept && (r_cnt == w_last);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
      r_dia   <= '0;
      r_addra <= '0;
      r_wea   <= 1'b0;
      r_w     <= '0;
      r_b     <= '0;
      r_first <= 1'b0;
      r_word  <= '0;
`ifdef SK_RETAIN_EN
      r_key_mode  <= 1'b0;
      r_key_valid <= 1'b0;
`endif
    end else begin
      r_wea <= w_accept;
      if (w_accept) begin
        r_dia   <= in_data;
        r_addra <= w_base + r_cnt;
        r_cnt   <= w_load_done ? 11'd0 : r_cnt + 11'd1;
      end
`ifdef SK_RETAIN_EN
      if (w_accept && (r_cnt == 11'd0)) r_key_mode <= key_load;
      if (w_load_done && w_key) r_key_valid <= 1'b1;
`endif
      case (r_state)
        S_LOAD:  if (w_load_done) r_state <= w_after_load;
        S_FLUSH: r_state <= S_START;
        S_START: r_state <= S_WAIT;
        S_WAIT: begin
          if (dec_done) begin
            r_w     <= '0;
            r_state <= S_RD;
          end
        end
        S_RD: begin
          r_first <= 1'b1;
          r_b     <= '0;
          r_state <= S_SEND;
        end
        S_SEND: begin
          // First SEND cycle forwards dec_out_do directly while latching it for later bytes.
          if (r_first) begin
            r_word  <= dec_out_do;
            r_first <= 1'b0;
          end
          if (out_ready) begin
            r_b <= r_b + 2'd1;
            if (r_b == 2'd3) begin
              if (r_w == LAST_W) begin
                r_state <= S_LOAD;
              end else begin
                r_w     <= r_w + 3'd1;
                r_state <= S_RD;
              end
            end
          end
        end
        default: r_state <= S_LOAD;
      endcase
    end
  end

  assign w_word       = r_first ? dec_out_do : r_word;
  assign out_data     = w_word[{r_b, 3'b000} +: 8];
  assign out_valid    = (r_state == S_SEND);
  assign out_last     = out_valid && (r_w == LAST_W) && (r_b == 2'd3);
  assign in_ready     = (r_state == S_LOAD);
  assign busy         = (r_state != S_LOAD);
  assign dec_start    = (r_state == S_START);
  assign dec_rst      = ~rst;
  assign dec_dia      = r_dia;
  assign dec_wea      = r_wea;
  assign dec_addra    = r_addra;
  assign dec_out_addr = r_w;

endmodule

// File: tb/tb_decrypt_stream_ctrl.sv
// Randomized bench for decrypt_stream_ctrl with a decrypter model and a byte-level reference of the stream.
module tb_decrypt_stream_ctrl;

`ifdef SK_RETAIN_EN
  localparam int CT_N = 1088;
`else
  localparam int CT_N = 1984;
`endif
  localparam int SK_N = 896;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_last;
  logic        busy;
  logic        dec_rst;
  logic        dec_start;
  logic        dec_done;
  logic        dec_done_m = 1'b0;
  logic        spur_done = 1'b0;
  logic [7:0]  dec_dia;
  logic        dec_wea;
  logic [10:0] dec_addra;
  logic [2:0]  dec_out_addr;
  logic [31:0] dec_out_do = '0;
`ifdef SK_RETAIN_EN
  logic        key_load = 1'b0;
  logic        key_valid;
`endif

  assign dec_done = dec_done_m | spur_done;

  decrypt_stream_ctrl dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .dec_rst(dec_rst), .dec_start(dec_start), .dec_done(dec_done),
    .dec_dia(dec_dia), .dec_wea(dec_wea), .dec_addra(dec_addra),
    .dec_out_addr(dec_out_addr), .dec_out_do(dec_out_do)
`ifdef SK_RETAIN_EN
    , .key_load(key_load), .key_valid(key_valid)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  int          cyc = 0;
  int          n_total = 0;
  int          n_bad = 0;
  int          n_wr = 0;
  int          n_start = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          last_acc_cyc = 0;
  int          done_at = -1;
  wr_t         exp_wr[$];
  logic [31:0] words[8];
  logic [7:0]  exp_bytes[32];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Decrypter model: done 50 cycles after start, message word readable one cycle after its address.
  initial begin
    logic [2:0] a_prev;
    logic       st;
    logic       rs;
    forever begin
      @(negedge clk);
      a_prev = dec_out_addr;
      st     = dec_start;
      rs     = dec_rst;
      if (rs) done_at = -1;
      else if (st) done_at = cyc + 50;
      @(posedge clk);
      #1;
      dec_out_do = words[a_prev];
      dec_done_m = !rs && (cyc == done_at);
    end
  end

  // Write-port and start monitor.
  always @(negedge clk) begin
    if (rst && dec_wea) begin
      if (exp_wr.size() == 0) begin
        check_eq("wr_extra", 32'(dec_addra), 32'hFFFF);
      end else begin
        wr_t e;
        e = exp_wr.pop_front();
        check_eq("wr_addr", 32'(dec_addra), 32'(e.addr));
        check_eq("wr_data", 32'(dec_dia), 32'(e.data));
        check_eq("wr_lat", cyc, e.cyc + 1);
      end
      n_wr <= n_wr + 1;
    end
    if (rst && dec_start) begin
      check_eq("start_lat", cyc, last_acc_cyc + 2);
      n_start <= n_start + 1;
      start_cyc <= cyc;
    end
    if (rst && dec_done_m) done_cyc <= cyc;
  end

  task automatic load(input int n, input int base, input bit gaps, input bit addr_data, input bit kl);
    int idx = 0;
    int guard = 0;
    bit v;
    logic [7:0] d;
    wr_t e;
`ifdef SK_RETAIN_EN
    key_load = kl;
`endif
    while (idx < n) begin
      if (guard++ > 4 * n + 100) begin
        check_eq("load_timeout", idx, n);
        break;
      end
      @(negedge clk);
      v = gaps ? ($urandom % 4 != 0) : 1'b1;
      d = addr_data ? 8'(base + idx) : 8'($urandom);
      in_valid = v;
      in_data  = d;
      if (v && in_ready) begin
        e.addr = 11'(base + idx);
        e.data = d;
        e.cyc  = cyc;
        exp_wr.push_back(e);
        last_acc_cyc = cyc;
        idx++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
`ifdef SK_RETAIN_EN
    key_load = 1'b0;
`endif
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2;
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    spur_done = 1'b0;
    exp_wr.delete();
    @(posedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_last", out_last, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_dec_rst", dec_rst, 1);
    check_eq("rst_start", dec_start, 0);
    check_eq("rst_wea", dec_wea, 0);
    check_eq("rst_dia", 32'(dec_dia), 0);
    check_eq("rst_addra", 32'(dec_addra), 0);
    check_eq("rst_out_addr", 32'(dec_out_addr), 0);
`ifdef SK_RETAIN_EN
    check_eq("rst_key_valid", key_valid, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_eq("no_partial", out_valid, 0);
    end
  endtask

  // kill: 0 none, 1 reset while waiting for done, 2 reset in SEND after byte 10
  task automatic run_op(input bit addr_data, input bit gaps, input bit ready_all,
                        input bit spur, input int kill);
    int st0, wr0, rx, guard, first_cyc, last_cyc;
    bit stall, first_seen, rdy;
    logic [7:0] held;
    logic [31:0] mask;
    for (int i = 0; i < 8; i++) begin
      mask = addr_data ? 32'h0 : $urandom;
      words[i] = (32'h03020100 + 32'h04040404 * i) ^ mask;
      for (int j = 0; j < 4; j++) exp_bytes[4 * i + j] = words[i][8 * j +: 8];
    end
    st0 = n_start;
    wr0 = n_wr;
    rx = 0;
    stall = 0;
    first_seen = 0;
    first_cyc = 0;
    last_cyc = 0;
    held = '0;
    load(CT_N, 0, gaps, addr_data, 1'b0);
    guard = 0;
    while (rx < 32) begin
      if (guard++ > 3000) begin
        check_eq("out_timeout", rx, 32);
        break;
      end
      @(negedge clk);
      if (kill == 1 && n_start > st0 && cyc >= start_cyc + 10) begin
        do_reset();
        return;
      end
      if (kill == 2 && rx == 11) begin
        do_reset();
        return;
      end
      if (out_valid) begin
        if (!first_seen) begin
          first_seen = 1;
          first_cyc = cyc;
        end
        if (stall) check_eq("hold_data", 32'(out_data), 32'(held));
        rdy = ready_all ? 1'b1 : 1'($urandom % 2);
        out_ready = rdy;
        if (rdy) begin
          check_eq("byte", 32'(out_data), 32'(exp_bytes[rx]));
          check_eq("last", out_last, rx == 31);
          rx++;
          last_cyc = cyc;
          stall = 0;
        end else begin
          stall = 1;
          held = out_data;
        end
        if (spur && rx < 28) begin
          in_valid = 1'($urandom % 2);
          in_data = 8'($urandom);
          spur_done = ($urandom % 4 == 0);
          if (in_valid) check_eq("in_ready_busy", in_ready, 0);
        end else begin
          in_valid = 1'b0;
          spur_done = 1'b0;
        end
      end else begin
        if (stall) check_eq("hold_valid", out_valid, 1);
        stall = 0;
        out_ready = ready_all ? 1'b1 : 1'($urandom % 2);
        in_valid = 1'b0;
        spur_done = 1'b0;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    spur_done = 1'b0;
    out_ready = 1'b0;
    check_eq("rx_count", rx, 32);
    check_eq("start_count", n_start - st0, 1);
    check_eq("wr_count", n_wr - wr0, CT_N);
    check_eq("wr_pending", exp_wr.size(), 0);
    check_eq("idle_busy", busy, 0);
    check_eq("idle_out_valid", out_valid, 0);
    if (ready_all) begin
      check_eq("first_out_lat", first_cyc - done_cyc, 2);
      check_eq("out_span", last_cyc - first_cyc, 38);
    end
  endtask

`ifdef SK_RETAIN_EN
  task automatic key_op();
    int st0, wr0;
    st0 = n_start;
    wr0 = n_wr;
    load(SK_N, CT_N, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check_eq("key_no_start", n_start - st0, 0);
    check_eq("key_wr_count", n_wr - wr0, SK_N);
    check_eq("key_valid", key_valid, 1);
    check_eq("key_busy", busy, 0);
  endtask

  task automatic ct_without_key();
    int st0, wr0;
    st0 = n_start;
    wr0 = n_wr;
    load(CT_N, 0, 1'b0, 1'b0, 1'b0);
    repeat (60) @(negedge clk);
    check_eq("nokey_no_start", n_start - st0, 0);
    check_eq("nokey_wr_count", n_wr - wr0, CT_N);
    check_eq("nokey_busy", busy, 0);
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) words[i] = '0;
    do_reset();
`ifdef SK_RETAIN_EN
    ct_without_key();
    key_op();
`endif
    run_op(1'b1, 1'b0, 1'b1, 1'b0, 0);
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 0);
    run_op(1'b0, 1'b0, 1'b0, 1'b0, 1);
`ifdef SK_RETAIN_EN
    key_op();
`endif
    run_op(1'b0, 1'b1, 1'b0, 1'b1, 0);
    run_op(1'b0, 1'b0, 1'b0, 1'b1, 2);
`ifdef SK_RETAIN_EN
    key_op();
`endif
    run_op(1'b0, 1'b0, 1'b1, 1'b0, 0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
